// File: rtl/multicycle_control_unit_if.sv
// Control-unit <-> datapath bundle: opcode/ALU flags in, datapath strobes out.
// master = control unit, slave = datapath side.
interface multicycle_control_unit_if #(
  parameter int unsigned OPW    = 4,
  parameter int unsigned ALUOPW = 3,
  parameter int unsigned STW    = 4
);
  logic [OPW-1:0]    opcode;
  logic              Z;
  logic              N;
  logic              mem_ready;
  logic [ALUOPW-1:0] ALUOp;
  logic              En;
  logic              alu_src_a;
  logic [1:0]        alu_src_b;
  logic              pc_write;
  logic [1:0]        pc_src;
  logic              ir_write;
  logic              mem_read;
  logic              mem_write;
  logic              reg_write;
  logic              mem_to_reg;
  logic              illegal_op;
  logic              halted;
  logic [STW-1:0]    state;

  modport master (
    input  opcode, Z, N, mem_ready,
    output ALUOp, En, alu_src_a, alu_src_b, pc_write, pc_src, ir_write,
           mem_read, mem_write, reg_write, mem_to_reg, illegal_op, halted, state
  );

  modport slave (
    output opcode, Z, N, mem_ready,
    input  ALUOp, En, alu_src_a, alu_src_b, pc_write, pc_src, ir_write,
           mem_read, mem_write, reg_write, mem_to_reg, illegal_op, halted, state
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Control FSM for the 16-bit multi-cycle datapath (fetch/decode/exec/mem/wb).
// Optional macro CTRL_MEM_WAIT_EN: memory states stall until mem_ready.
module multicycle_control_unit (
  input  logic                        clk,
  input  logic                        reset,
  multicycle_control_unit_if.master   bus
);
  localparam int unsigned OPW    = 4;
  localparam int unsigned ALUOPW = 3;
  localparam int unsigned STW    = 4;

  typedef enum logic [STW-1:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC_R = 4'd3,
    S_EXEC_I = 4'd4,
    S_ADDR   = 4'd5,
    S_MEM_RD = 4'd6,
    S_MEM_WR = 4'd7,
    S_WB_ALU = 4'd8,
    S_WB_MEM = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11,
    S_HALT   = 4'd12
  } state_t;

  localparam logic [OPW-1:0] OP_ADDI = 4'd5;
  localparam logic [OPW-1:0] OP_LW   = 4'd6;
  localparam logic [OPW-1:0] OP_SW   = 4'd7;
  localparam logic [OPW-1:0] OP_BEQ  = 4'd8;
  localparam logic [OPW-1:0] OP_BLT  = 4'd9;
  localparam logic [OPW-1:0] OP_JMP  = 4'd10;
  localparam logic [OPW-1:0] OP_HALT = 4'd15;

  localparam logic [ALUOPW-1:0] ALU_ADD = 3'b000;
  localparam logic [ALUOPW-1:0] ALU_SUB = 3'b001;

  typedef struct packed {
    logic [ALUOPW-1:0] aluop;
    logic              en;
    logic              src_a;
    logic [1:0]        src_b;
    logic              pc_write;
    logic [1:0]        pc_src;
    logic              ir_write;
    logic              mem_read;
    logic              mem_write;
    logic              reg_write;
    logic              mem_to_reg;
    logic              halted;
  } ctl_t;

  // Moore strobes for a given state; registered against the next state.
  function automatic ctl_t moore(input state_t s, input logic [ALUOPW-1:0] rop);
    ctl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_read = 1'b1;
        c.ir_write = 1'b1;
        c.pc_write = 1'b1;
        c.en       = 1'b1;
        c.aluop    = ALU_ADD;
        c.src_b    = 2'b01;
      end
      S_EXEC_R: begin
        c.en    = 1'b1;
        c.aluop = rop;
        c.src_a = 1'b1;
      end
      S_EXEC_I, S_ADDR: begin
        c.en    = 1'b1;
        c.aluop = ALU_ADD;
        c.src_a = 1'b1;
        c.src_b = 2'b10;
      end
      S_MEM_RD: c.mem_read  = 1'b1;
      S_MEM_WR: c.mem_write = 1'b1;
      S_WB_ALU: c.reg_write = 1'b1;
      S_WB_MEM: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_BRANCH: begin
        c.en     = 1'b1;
        c.aluop  = ALU_SUB;
        c.src_a  = 1'b1;
        c.pc_src = 2'b01;
      end
      S_JUMP: begin
        c.pc_write = 1'b1;
        c.pc_src   = 2'b10;
      end
      S_HALT:  c.halted = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

  state_t state_q;
  state_t nxt;
  ctl_t   ctl_q;
  logic   mem_go;
  logic   strobe_ok;
  logic   take;

`ifdef CTRL_MEM_WAIT_EN
  assign mem_go = bus.mem_ready;
`else
  assign mem_go = 1'b1;
`endif

  always_comb begin
    nxt = S_FETCH;
    case (state_q)
      S_IDLE:   nxt = S_FETCH;
      S_FETCH:  nxt = mem_go ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.opcode)
          4'd0, 4'd1, 4'd2, 4'd3, 4'd4: nxt = S_EXEC_R;
          OP_ADDI:                      nxt = S_EXEC_I;
          OP_LW, OP_SW:                 nxt = S_ADDR;
          OP_BEQ, OP_BLT:               nxt = S_BRANCH;
          OP_JMP:                       nxt = S_JUMP;
          OP_HALT:                      nxt = S_HALT;
          default:                      nxt = S_FETCH;
        endcase
      end
      S_EXEC_R: nxt = S_WB_ALU;
      S_EXEC_I: nxt = S_WB_ALU;
      S_ADDR:   nxt = (bus.opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: nxt = mem_go ? S_WB_MEM : S_MEM_RD;
      S_MEM_WR: nxt = mem_go ? S_FETCH : S_MEM_WR;
      S_WB_ALU: nxt = S_FETCH;
      S_WB_MEM: nxt = S_FETCH;
      S_BRANCH: nxt = S_FETCH;
      S_JUMP:   nxt = S_FETCH;
      S_HALT:   nxt = S_HALT;
      default:  nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      ctl_q   <= '0;
    end else begin
      state_q <= nxt;
      ctl_q   <= moore(nxt, bus.opcode[ALUOPW-1:0]);
    end
  end

  // Fetch-side loads fire only on the cycle memory completes.
  assign strobe_ok = (state_q != S_FETCH) || mem_go;
  // Branch decision follows the live ALU flags in the same cycle.
  assign take = (state_q == S_BRANCH) &&
                (((bus.opcode == OP_BEQ) && bus.Z) || ((bus.opcode == OP_BLT) && bus.N));

  assign bus.ALUOp      = ctl_q.aluop;
  assign bus.En         = ctl_q.en;
  assign bus.alu_src_a  = ctl_q.src_a;
  assign bus.alu_src_b  = ctl_q.src_b;
  assign bus.pc_write   = (ctl_q.pc_write && strobe_ok) || take;
  assign bus.pc_src     = ctl_q.pc_src;
  assign bus.ir_write   = ctl_q.ir_write && strobe_ok;
  assign bus.mem_read   = ctl_q.mem_read;
  assign bus.mem_write  = ctl_q.mem_write;
  assign bus.reg_write  = ctl_q.reg_write;
  assign bus.mem_to_reg = ctl_q.mem_to_reg;
  assign bus.halted     = ctl_q.halted;
  assign bus.illegal_op = (state_q == S_DECODE) && (bus.opcode inside {[4'd11:4'd14]});
  assign bus.state      = state_q;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: directed vector table, corner sequences,
// and random instruction streams against an instruction-level model.
module tb_multicycle_control_unit;
  logic clk;
  logic reset;

  multicycle_control_unit_if bus ();

  multicycle_control_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [3:0] st;
    logic [2:0] aluop;
    logic       en;
    logic       src_a;
    logic [1:0] src_b;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       illegal_op;
    logic       halted;
  } exp_t;

  typedef struct {
    logic [3:0] op;
    logic       z;
    logic       n;
    int         lat;
    logic [2:0] flags; // {pc_write seen after fetch, illegal seen, reg_write seen}
  } vec_t;

  int   n_checks = 0;
  int   n_fails  = 0;
  exp_t exp_q[$];
  vec_t tab[16];

  function automatic exp_t sample();
    exp_t s;
    s.st         = bus.state;
    s.aluop      = bus.ALUOp;
    s.en         = bus.En;
    s.src_a      = bus.alu_src_a;
    s.src_b      = bus.alu_src_b;
    s.pc_write   = bus.pc_write;
    s.pc_src     = bus.pc_src;
    s.ir_write   = bus.ir_write;
    s.mem_read   = bus.mem_read;
    s.mem_write  = bus.mem_write;
    s.reg_write  = bus.reg_write;
    s.mem_to_reg = bus.mem_to_reg;
    s.illegal_op = bus.illegal_op;
    s.halted     = bus.halted;
    return s;
  endfunction

  task automatic check(input string name, input exp_t want);
    exp_t got;
    got = sample();
    n_checks++;
    if (got !== want) begin
      n_fails++;
      $display("FAIL %s: got %h (state %0d) expected %h (state %0d) at %0t",
               name, got, got.st, want, want.st, $time);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  // Per-cycle expectation for one instruction, written from the instruction's meaning.
  task automatic build(input logic [3:0] op, input logic z, input logic n);
    exp_t e;
    exp_q.delete();
    e = '0; e.st = 4'd1; e.mem_read = 1'b1; e.ir_write = 1'b1; e.pc_write = 1'b1;
    e.en = 1'b1; e.src_b = 2'b01;
    exp_q.push_back(e);
    e = '0; e.st = 4'd2; e.illegal_op = (op >= 4'd11 && op <= 4'd14);
    exp_q.push_back(e);
    if (op <= 4'd4) begin
      e = '0; e.st = 4'd3; e.en = 1'b1; e.aluop = op[2:0]; e.src_a = 1'b1;
      exp_q.push_back(e);
      e = '0; e.st = 4'd8; e.reg_write = 1'b1;
      exp_q.push_back(e);
    end else if (op == 4'd5) begin
      e = '0; e.st = 4'd4; e.en = 1'b1; e.src_a = 1'b1; e.src_b = 2'b10;
      exp_q.push_back(e);
      e = '0; e.st = 4'd8; e.reg_write = 1'b1;
      exp_q.push_back(e);
    end else if (op == 4'd6 || op == 4'd7) begin
      e = '0; e.st = 4'd5; e.en = 1'b1; e.src_a = 1'b1; e.src_b = 2'b10;
      exp_q.push_back(e);
      if (op == 4'd6) begin
        e = '0; e.st = 4'd6; e.mem_read = 1'b1;
        exp_q.push_back(e);
        e = '0; e.st = 4'd9; e.reg_write = 1'b1; e.mem_to_reg = 1'b1;
        exp_q.push_back(e);
      end else begin
        e = '0; e.st = 4'd7; e.mem_write = 1'b1;
        exp_q.push_back(e);
      end
    end else if (op == 4'd8 || op == 4'd9) begin
      e = '0; e.st = 4'd10; e.en = 1'b1; e.aluop = 3'b001; e.src_a = 1'b1;
      e.pc_src = 2'b01; e.pc_write = (op == 4'd8) ? z : n;
      exp_q.push_back(e);
    end else if (op == 4'd10) begin
      e = '0; e.st = 4'd11; e.pc_write = 1'b1; e.pc_src = 2'b10;
      exp_q.push_back(e);
    end else if (op == 4'd15) begin
      e = '0; e.st = 4'd12; e.halted = 1'b1;
      for (int k = 0; k < 20; k++) exp_q.push_back(e);
    end
  endtask

  // Runs one instruction starting on its FETCH cycle; flags are only observed values.
  task automatic run_instr(input logic [3:0] op, input logic z, input logic n,
                           input string tag, output int lat, output logic [2:0] flags);
    exp_t a;
    build(op, z, n);
    lat   = 1;
    flags = 3'b000;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(posedge clk);
      #1;
      if (i == 0) bus.opcode = op;
      if (exp_q[i].st == 4'd10) begin
        bus.Z = z;
        bus.N = n;
      end else begin
        bus.Z = 1'($urandom);
        bus.N = 1'($urandom);
      end
`ifndef CTRL_MEM_WAIT_EN
      bus.mem_ready = 1'($urandom);
`endif
      #1;
      check(tag, exp_q[i]);
      a = sample();
      if (i > 0) begin
        if (a.st != 4'd1) lat++;
        flags = flags | {a.pc_write, a.illegal_op, a.reg_write};
      end
    end
  endtask

  // Async assert mid-cycle, hold across an edge, release into IDLE.
  task automatic apply_reset(input string tag);
    reset = 1'b1;
    #1;
    check({tag, "_assert"}, '0);
    @(posedge clk);
    #1;
    check({tag, "_hold"}, '0);
    reset = 1'b0;
    #1;
    check({tag, "_release"}, '0);
  endtask

  initial begin
    int         lat;
    logic [2:0] flags;
    exp_t       e;

    tab[0]  = '{4'd0,  1'b0, 1'b0, 4, 3'b001};
    tab[1]  = '{4'd1,  1'b0, 1'b0, 4, 3'b001};
    tab[2]  = '{4'd2,  1'b1, 1'b0, 4, 3'b001};
    tab[3]  = '{4'd3,  1'b0, 1'b1, 4, 3'b001};
    tab[4]  = '{4'd4,  1'b0, 1'b0, 4, 3'b001};
    tab[5]  = '{4'd5,  1'b0, 1'b0, 4, 3'b001};
    tab[6]  = '{4'd6,  1'b0, 1'b0, 5, 3'b001};
    tab[7]  = '{4'd7,  1'b0, 1'b0, 4, 3'b000};
    tab[8]  = '{4'd8,  1'b1, 1'b0, 3, 3'b100};
    tab[9]  = '{4'd8,  1'b0, 1'b1, 3, 3'b000};
    tab[10] = '{4'd9,  1'b0, 1'b1, 3, 3'b100};
    tab[11] = '{4'd9,  1'b1, 1'b0, 3, 3'b000};
    tab[12] = '{4'd10, 1'b0, 1'b0, 3, 3'b100};
    tab[13] = '{4'd11, 1'b0, 1'b0, 2, 3'b010};
    tab[14] = '{4'd13, 1'b1, 1'b1, 2, 3'b010};
    tab[15] = '{4'd14, 1'b0, 1'b0, 2, 3'b010};

    reset         = 1'b1;
    bus.opcode    = 4'd0;
    bus.Z         = 1'b0;
    bus.N         = 1'b0;
    bus.mem_ready = 1'b1;
    #2;
    apply_reset("power_on");

    foreach (tab[t]) begin
      run_instr(tab[t].op, tab[t].z, tab[t].n, $sformatf("vec%0d", t), lat, flags);
      check_int($sformatf("vec%0d_latency", t), lat, tab[t].lat);
      check_int($sformatf("vec%0d_flags", t), int'(flags), int'(tab[t].flags));
    end

    run_instr(4'd15, 1'b0, 1'b0, "halt_hold", lat, flags);
    apply_reset("halt_exit");

    // Reset landing in EXEC_R of a SUB drops every pending strobe.
    build(4'd1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      if (i == 0) bus.opcode = 4'd1;
      #1;
      check("sub_pre_reset", exp_q[i]);
    end
    apply_reset("mid_exec");

`ifdef CTRL_MEM_WAIT_EN
    bus.opcode = 4'd0;
    e = '0; e.st = 4'd1; e.mem_read = 1'b1; e.en = 1'b1; e.src_b = 2'b01;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      bus.mem_ready = 1'b0;
      #1;
      check("fetch_wait", e);
    end
    @(posedge clk);
    #1;
    bus.mem_ready = 1'b1;
    #1;
    e.ir_write = 1'b1;
    e.pc_write = 1'b1;
    check("fetch_ready", e);
    @(posedge clk);
    #2;
    e = '0; e.st = 4'd2;
    check("decode_after_wait", e);
    apply_reset("wait_exit");
`endif

    for (int r = 0; r < 200; r++) begin
      run_instr(4'($urandom_range(0, 14)), 1'($urandom), 1'($urandom), "random", lat, flags);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
